// File: rtl/div_if.sv
// Handshake and operand/result bundle between the EX stage and the divider.
interface div_if;
  logic        flush;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        stallreq_for_ex;
  logic        result_valid;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  modport master (
    output flush, start, signed_div, opdata1, opdata2,
    input  stallreq_for_ex, result_valid, result_hi, result_lo
  );

  modport slave (
    input  flush, start, signed_div, opdata1, opdata2,
    output stallreq_for_ex, result_valid, result_hi, result_lo
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: zero divisor/dividend finish in one cycle.
module div_unit (
  input  logic  clk,
  input  logic  resetn,
  div_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  sr_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    divisor_q;
  logic [W-1:0]    dividend_q;
  logic            div_zero_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;

  logic            load;
  logic            step;
  logic            fin_busy;
`ifdef DIV_EARLY_OUT_EN
  logic            fin_early;
`endif

  logic            a_neg, b_neg;
  logic [W-1:0]    abs_a, abs_b;
  logic [2*W-1:0]  shifted;
  logic [W:0]      diff;
  logic [2*W-1:0]  sr_step;
  logic [W-1:0]    fin_quo, fin_rem;
  logic [W-1:0]    lo_fix, hi_fix;

  // Operand magnitudes for the unsigned core
  assign a_neg = bus.signed_div & bus.opdata1[W-1];
  assign b_neg = bus.signed_div & bus.opdata2[W-1];
  assign abs_a = a_neg ? W'(-bus.opdata1) : bus.opdata1;
  assign abs_b = b_neg ? W'(-bus.opdata2) : bus.opdata2;

  // One restoring step; the bit shifted out of the top joins the 33-bit compare
  assign shifted = {sr_q[2*W-2:0], 1'b0};
  assign diff    = {sr_q[2*W-1], shifted[2*W-1:W]} - {1'b0, divisor_q};
  assign sr_step = diff[W] ? shifted : {diff[W-1:0], shifted[W-1:1], 1'b1};

  assign fin_quo = sr_step[W-1:0];
  assign fin_rem = sr_step[2*W-1:W];
  assign lo_fix  = div_zero_q ? {W{1'b1}} : (neg_quo_q ? W'(-fin_quo) : fin_quo);
  assign hi_fix  = div_zero_q ? dividend_q : (neg_rem_q ? W'(-fin_rem) : fin_rem);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    fin_busy = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    fin_early = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          if (bus.opdata2 == '0 || bus.opdata1 == '0) begin
            fin_early = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == CW'(W-1)) begin
          fin_busy = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides everything and drops any partial result
    if (bus.flush) begin
      state_d  = IDLE;
      load     = 1'b0;
      step     = 1'b0;
      fin_busy = 1'b0;
`ifdef DIV_EARLY_OUT_EN
      fin_early = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      div_zero_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (load) begin
      sr_q       <= {W'(0), abs_a};
      cnt_q      <= '0;
      divisor_q  <= abs_b;
      dividend_q <= bus.opdata1;
      div_zero_q <= (bus.opdata2 == '0);
      neg_quo_q  <= bus.signed_div & (bus.opdata1[W-1] ^ bus.opdata2[W-1]);
      neg_rem_q  <= a_neg;
    end else if (step) begin
      sr_q  <= sr_step;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Results change only on the way into DONE and hold otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fin_busy) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (fin_early) begin
      hi_q <= (bus.opdata2 == '0) ? bus.opdata1 : '0;
      lo_q <= (bus.opdata2 == '0) ? {W{1'b1}} : '0;
    end
`endif
  end

  assign bus.stallreq_for_ex = resetn & ~bus.flush &
                               (((state_q == IDLE) & bus.start) | (state_q == BUSY));
  assign bus.result_valid    = (state_q == DONE) & ~bus.flush;
  assign bus.result_hi       = hi_q;
  assign bus.result_lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  logic clk;
  logic resetn;
  div_if bus ();

  int n_vec;
  int n_err;

`ifdef DIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division at cycle k=0 and track stall count, latency and results
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
    int lat;
    int stalls;
    logic [31:0] lo;
    logic [31:0] hi;
    lat = -1; stalls = 0; lo = '0; hi = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = sd; bus.opdata1 = a; bus.opdata2 = b;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.stallreq_for_ex) stalls++;
      if (bus.result_valid) begin
        lat = k; lo = bus.result_lo; hi = bus.result_hi;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check_eq({tag, " lo"}, lo, exp_lo);
    check_eq({tag, " hi"}, hi, exp_hi);
    @(negedge clk);
    check_eq({tag, " valid_one_cycle"}, 32'(bus.result_valid), 32'd0);
    check_eq({tag, " lo_hold"}, bus.result_lo, exp_lo);
  endtask

  initial begin
    int nvalid;
    n_vec = 0; n_err = 0;
    resetn = 1'b0;
    bus.flush = 1'b0; bus.start = 1'b1; bus.signed_div = 1'b0;
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst stall", 32'(bus.stallreq_for_ex), 32'd0);
    check_eq("rst valid", 32'(bus.result_valid), 32'd0);
    check_eq("rst lo", bus.result_lo, 32'd0);
    check_eq("rst hi", bus.result_hi, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; bus.start = 1'b0;

    run_div("divu_100_7",   1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        33);
    run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       33);
    run_div("divu_55_0",    1'b0, 32'd55,         32'd0,        32'hFFFF_FFFF, 32'd55,       ZLAT);
    run_div("div_m55_0",    1'b1, 32'hFFFF_FFC9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFC9, ZLAT);
    run_div("div_0_5",      1'b1, 32'd0,          32'd5,        32'd0,         32'd0,        ZLAT);
    run_div("divu_max_2",   1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'd1,        33);
    run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       33);
    run_div("div_m7_m2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 33);
    run_div("divu_big_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33);

    // flush and start together in IDLE must not launch a division
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.signed_div = 1'b0;
    bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
    @(negedge clk);
    check_eq("fs stall", 32'(bus.stallreq_for_ex), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check_eq("fs idle", 32'(bus.stallreq_for_ex), 32'd0);

    // flush mid-division at k=10, then restart at k=12
    nvalid = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd50; bus.opdata2 = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush stall", 32'(bus.stallreq_for_ex), 32'd0);
    check_eq("flush valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush idle", 32'(bus.stallreq_for_ex), 32'd0);
    check_eq("flush lo_kept", bus.result_lo, 32'd0);
    check_eq("flush hi_kept", bus.result_hi, 32'h8000_0000);
    check_eq("flush no_valid", 32'(nvalid), 32'd0);
    run_div("after_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // reset pulse at k=5 aborts the division
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b1; bus.opdata1 = 32'd77; bus.opdata2 = 32'd5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    check_eq("rstb stall", 32'(bus.stallreq_for_ex), 32'd0);
    check_eq("rstb valid", 32'(bus.result_valid), 32'd0);
    check_eq("rstb lo", bus.result_lo, 32'd0);
    check_eq("rstb hi", bus.result_hi, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
    end
    check_eq("rstb no_valid", 32'(nvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
